// File: rtl/hazard_controller.sv
// hazard_controller: per-cycle advance/stall/bubble/flush/hold decisions for
// the 5-stage, 19-bit-instruction pipeline. Covers load-use bubbles, taken
// branch flushes, data-memory wait with timeout fault, and post-reset clearing.
// Optional feature macro: HAZARD_PERF_EN (saturating performance counters).
module hazard_controller #(
    parameter int unsigned INIT_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [18:0]       id_inst,
    input  logic              id_reg2_read_source,
    input  logic [18:0]       ex_inst,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_hold,
    output logic              fault,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  wait_cnt_total
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_V = 16'(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [3:0]  init_cnt, init_cnt_next;
    logic [15:0] wait_cnt, wait_cnt_next;
    logic        flush_pending, flush_pending_next;

    // One-cycle event strobes feeding the optional performance counters
    logic        ev_bubble, ev_flush, ev_frozen;

    logic [2:0]  dest, src1, src2_sel;
    logic        load_use, mem_frozen;

    // Only the register fields of the instructions matter here
    logic        unused_inst_bits;
    assign unused_inst_bits = ^{id_inst[18:11], id_inst[4:0], ex_inst[18:14], ex_inst[10:0]};

    // Operand/destination decode and hazard conditions
    always_comb begin
        dest       = ex_inst[13:11];
        src1       = id_inst[10:8];
        src2_sel   = id_reg2_read_source ? id_inst[10:8] : id_inst[7:5];
        load_use   = ex_mem_read && (dest != 3'd0) && ((dest == src1) || (dest == src2_sel));
        mem_frozen = mem_req && !mem_ready;
    end

    // State, init counter, wait counter and deferred-flush flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_next;
            init_cnt      <= init_cnt_next;
            wait_cnt      <= wait_cnt_next;
            flush_pending <= flush_pending_next;
        end
    end

    // Next-state and Mealy control outputs in priority order
    always_comb begin
        state_next         = state;
        init_cnt_next      = init_cnt;
        wait_cnt_next      = wait_cnt;
        flush_pending_next = flush_pending;
        pc_write           = 1'b0;
        if_id_write        = 1'b0;
        if_id_flush        = 1'b0;
        id_ex_flush        = 1'b0;
        pipe_hold          = 1'b0;
        fault              = 1'b0;
        ev_bubble          = 1'b0;
        ev_flush           = 1'b0;
        ev_frozen          = 1'b0;

        case (state)
            S_INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_next    = S_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt + 4'd1;
                end
            end

            // RUN and MEM_WAIT share the frozen response and the case 2-4
            // decision; they differ only in wait-counter handling and in
            // whether a branch seen during the stall is replayed.
            S_RUN, S_MEM_WAIT: begin
                if (mem_frozen) begin
                    pipe_hold = 1'b1;
                    ev_frozen = 1'b1;
                    if (state == S_RUN) begin
                        state_next         = S_MEM_WAIT;
                        wait_cnt_next      = 16'd1;
                        flush_pending_next = ex_branch_taken;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        state_next = S_FAULT;
                    end else begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                end else begin
                    state_next         = S_RUN;
                    flush_pending_next = 1'b0;
                    if (ex_branch_taken || flush_pending) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        ev_flush    = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush = 1'b1;
                        ev_bubble   = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
            end

            default: begin
                pipe_hold = 1'b1;
                fault     = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt      <= '0;
            flush_cnt      <= '0;
            wait_cnt_total <= '0;
        end else begin
            if (ev_bubble && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ev_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (ev_frozen && (wait_cnt_total != CNT_MAX))
                wait_cnt_total <= wait_cnt_total + CNT_W'(1);
        end
    end
`else
    logic unused_events;
    assign unused_events  = ev_bubble ^ ev_flush ^ ev_frozen;
    assign stall_cnt      = '0;
    assign flush_cnt      = '0;
    assign wait_cnt_total = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a driver issues directed then random
// stimulus and queues the reference model's expected response; a monitor on
// the falling edge pops and compares. Honours HAZARD_PERF_EN like the design.
module tb_hazard_controller;

    localparam int INIT_C = 3;
    localparam int TMO    = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [18:0]   id_inst;
    logic          id_reg2_read_source;
    logic [18:0]   ex_inst;
    logic          ex_mem_read;
    logic          ex_branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, fault;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt_total;

    hazard_controller #(
        .INIT_CYCLES(INIT_C),
        .MEM_TIMEOUT(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_inst(id_inst), .id_reg2_read_source(id_reg2_read_source),
        .ex_inst(ex_inst), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pipe_hold(pipe_hold), .fault(fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_total(wait_cnt_total)
    );

    always #5 clk = ~clk;

    // Output bundle order: pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, fault
    localparam logic [5:0] O_INIT   = 6'b001100;
    localparam logic [5:0] O_FAULT  = 6'b000011;
    localparam logic [5:0] O_FROZEN = 6'b000010;
    localparam logic [5:0] O_FLUSH  = 6'b111100;
    localparam logic [5:0] O_BUBBLE = 6'b000100;
    localparam logic [5:0] O_NORMAL = 6'b110000;

    typedef struct {
        int          cyc;
        logic [5:0]  outs;
        int          sc;
        int          fc;
        int          wc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: cycles spent clearing since reset release, length of
    // the current frozen run, a remembered branch, and a sticky fault.
    int   m_init_seen;
    int   m_frozen_run;
    bit   m_pending;
    bit   m_faulted;
    int   m_stalls, m_flushes, m_waits;

    function automatic bit is_load_use(logic [18:0] idi, bit rs, logic [18:0] exi, bit mr);
        int d, s1, s2;
        d  = int'(exi[13:11]);
        s1 = int'(idi[10:8]);
        s2 = rs ? s1 : int'(idi[7:5]);
        return mr && d != 0 && (d == s1 || d == s2);
    endfunction

    function automatic int sat_inc(int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic step(input bit r, input logic [18:0] idi, input bit rs,
                        input logic [18:0] exi, input bit mr, input bit br,
                        input bit mq, input bit mrdy);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; id_inst = idi; id_reg2_read_source = rs; ex_inst = exi;
        ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; mem_ready = mrdy;

        e.cyc = cyc;
        if (r) begin
            m_init_seen = 0; m_frozen_run = 0; m_pending = 0; m_faulted = 0;
            m_stalls = 0; m_flushes = 0; m_waits = 0;
        end
`ifdef HAZARD_PERF_EN
        e.sc = m_stalls; e.fc = m_flushes; e.wc = m_waits;
`else
        e.sc = 0; e.fc = 0; e.wc = 0;
`endif
        if (r) begin
            e.outs = O_INIT;
        end else if (m_faulted) begin
            e.outs = O_FAULT;
        end else if (m_init_seen < INIT_C) begin
            e.outs = O_INIT;
            m_init_seen++;
        end else if (mq && !mrdy) begin
            e.outs = O_FROZEN;
            if (m_frozen_run == 0) m_pending = br;
            m_frozen_run++;
            m_waits = sat_inc(m_waits);
            if (m_frozen_run == TMO + 1) m_faulted = 1;
        end else begin
            if (br || m_pending) begin
                e.outs = O_FLUSH;
                m_flushes = sat_inc(m_flushes);
            end else if (is_load_use(idi, rs, exi, mr)) begin
                e.outs = O_BUBBLE;
                m_stalls = sat_inc(m_stalls);
            end else begin
                e.outs = O_NORMAL;
            end
            m_frozen_run = 0;
            m_pending = 0;
        end
        sbq.push_back(e);
    endtask

    function automatic logic [18:0] mk_id(int s1, int s2);
        logic [18:0] v;
        v = 19'($urandom);
        v[10:8] = 3'(s1);
        v[7:5]  = 3'(s2);
        return v;
    endfunction

    function automatic logic [18:0] mk_ex(int d);
        logic [18:0] v;
        v = 19'($urandom);
        v[13:11] = 3'(d);
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t got;
        logic [5:0] act;
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, fault};
            n_cmp++;
            if (act !== got.outs) begin
                n_bad++;
                $display("FAIL ctrl cyc=%0d actual=%b required=%b (pcw,ifidw,ifidfl,idexfl,hold,fault)",
                         got.cyc, act, got.outs);
            end
            n_cmp++;
            if (stall_cnt !== CW'(got.sc) || flush_cnt !== CW'(got.fc) || wait_cnt_total !== CW'(got.wc)) begin
                n_bad++;
                $display("FAIL counters cyc=%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                         got.cyc, stall_cnt, flush_cnt, wait_cnt_total, got.sc, got.fc, got.wc);
            end
        end
    end

    initial begin
        rst = 1'b1; id_inst = '0; id_reg2_read_source = 1'b0; ex_inst = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        // Reset, then INIT_C clearing cycles, then normal flow
        step(1, mk_id(1, 2), 0, mk_ex(4), 0, 0, 0, 0);
        step(1, mk_id(1, 2), 0, mk_ex(4), 0, 0, 0, 0);
        idle(5);

        // Load-use on src1; dest 0 never stalls
        step(0, mk_id(3, 6), 0, mk_ex(3), 1, 0, 0, 0);
        idle(1);
        step(0, mk_id(0, 0), 0, mk_ex(0), 1, 0, 0, 0);
        // Selected src2 matches; then src2 ignored when source select is 1
        step(0, mk_id(2, 5), 0, mk_ex(5), 1, 0, 0, 0);
        step(0, mk_id(2, 5), 1, mk_ex(5), 1, 0, 0, 0);

        // Memory stall of 3 cycles with a branch in the first; deferred flush on release
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 1, 1, 0);
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 1);
        idle(1);

        // Branch and load-use together resolve as a branch
        step(0, mk_id(3, 3), 0, mk_ex(3), 1, 1, 0, 0);
        idle(1);

        // Timeout: fault after TMO+1 frozen cycles, sticky until reset
        for (int i = 0; i < TMO + 4; i++) step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        idle(2);
        step(1, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        idle(5);

        // Reset in the middle of a stall with a branch pending
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 1, 1, 0);
        step(0, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        step(1, mk_id(1, 2), 0, mk_ex(4), 0, 0, 1, 0);
        idle(5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int d, s1, s2;
            bit r, rs, mr, br, mq, mrdy;
            d  = $urandom_range(0, 7);
            s1 = ($urandom_range(0, 2) == 0) ? d : $urandom_range(0, 7);
            s2 = ($urandom_range(0, 2) == 0) ? d : $urandom_range(0, 7);
            r    = ($urandom_range(0, 79) == 0);
            rs   = $urandom_range(0, 1);
            mr   = $urandom_range(0, 1);
            br   = ($urandom_range(0, 5) == 0);
            mq   = ($urandom_range(0, 3) == 0) || (m_frozen_run > 0 && $urandom_range(0, 3) != 0);
            mrdy = $urandom_range(0, 1);
            step(r, mk_id(s1, s2), rs, mk_ex(d), mr, br, mq, mrdy);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d pending required=0 pending", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
